qs_bank_sched: RTL and testbench

QS_BANK_SCHED -- requirements
Module: qs_bank_sched

---
 rtl/qs_bank_sched.sv | 185 ++++++++++++++++++
 tb/tb_qs_bank_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qs_bank_sched.sv
// qs_bank_sched: hands a ring of BANKS_N sort banks to three stages
// (enq -> srt -> deq).  Each bank walks FREE->ENQ->SRT_PEND->SRT->DEQ_PEND->DEQ->FREE.
// Every stage walks the ring with its own pointer, so banks are sorted and drained
// in the order they were filled.
// Optional build macro: QS_BANK_SCHED_ERR_EN turns on the sticky err_r flag.
// err_r is raised by a done pulse that arrives while that stage holds no grant.
module qs_bank_sched #(
   parameter int BANKS_N = 2,
   localparam int IDX_W = $clog2(BANKS_N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enq_req,
   input  logic             enq_done,
   output logic             enq_gnt_vld_r,
   output logic [IDX_W-1:0] enq_gnt_idx_r,
   input  logic             srt_req,
   input  logic             srt_done,
   output logic             srt_gnt_vld_r,
   output logic [IDX_W-1:0] srt_gnt_idx_r,
   input  logic             deq_req,
   input  logic             deq_done,
   output logic             deq_gnt_vld_r,
   output logic [IDX_W-1:0] deq_gnt_idx_r,
   output logic [IDX_W:0]   free_cnt_r,
   output logic             err_r
);

   typedef enum logic [2:0] {
      BANK_FREE     = 3'd0,
      BANK_ENQ      = 3'd1,
      BANK_SRT_PEND = 3'd2,
      BANK_SRT      = 3'd3,
      BANK_DEQ_PEND = 3'd4,
      BANK_DEQ      = 3'd5
   } bank_state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANKS_N - 1);
   localparam logic [IDX_W:0]   FREE_ALL = (IDX_W + 1)'(BANKS_N);

   // Ring pointer step: wraps from the last bank back to bank 0.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] res;
      if (ptr == LAST_IDX) begin
         res = '0;
      end else begin
         res = ptr + IDX_W'(1);
      end
      return res;
   endfunction

   bank_state_t      bank_r     [BANKS_N];
   bank_state_t      bank_nxt_s [BANKS_N];
   logic [IDX_W-1:0] enq_ptr_r, srt_ptr_r, deq_ptr_r;
   logic [IDX_W-1:0] enq_ptr_nxt_s, srt_ptr_nxt_s, deq_ptr_nxt_s;
   logic             enq_vld_nxt_s, srt_vld_nxt_s, deq_vld_nxt_s;
   logic [IDX_W-1:0] enq_idx_nxt_s, srt_idx_nxt_s, deq_idx_nxt_s;
   logic [IDX_W:0]   free_nxt_s;
   logic             enq_gnt_s, srt_gnt_s, deq_gnt_s;
   logic             enq_rel_s, srt_rel_s, deq_rel_s;

   // Grant and release decode.  A grant needs an idle stage and a ready bank at its
   // pointer.  A release needs a done pulse while the stage holds a grant.
   assign enq_gnt_s = enq_req && !enq_gnt_vld_r && (bank_r[enq_ptr_r] == BANK_FREE);
   assign srt_gnt_s = srt_req && !srt_gnt_vld_r && (bank_r[srt_ptr_r] == BANK_SRT_PEND);
   assign deq_gnt_s = deq_req && !deq_gnt_vld_r && (bank_r[deq_ptr_r] == BANK_DEQ_PEND);
   assign enq_rel_s = enq_done && enq_gnt_vld_r;
   assign srt_rel_s = srt_done && srt_gnt_vld_r;
   assign deq_rel_s = deq_done && deq_gnt_vld_r;

   // Next-state logic.  The three stages always sit on different banks, so their
   // bank writes never collide and can be evaluated side by side.
   always_comb begin
      bank_nxt_s    = bank_r;
      enq_ptr_nxt_s = enq_ptr_r;
      srt_ptr_nxt_s = srt_ptr_r;
      deq_ptr_nxt_s = deq_ptr_r;
      enq_vld_nxt_s = enq_gnt_vld_r;
      srt_vld_nxt_s = srt_gnt_vld_r;
      deq_vld_nxt_s = deq_gnt_vld_r;
      enq_idx_nxt_s = enq_gnt_idx_r;
      srt_idx_nxt_s = srt_gnt_idx_r;
      deq_idx_nxt_s = deq_gnt_idx_r;
      free_nxt_s    = free_cnt_r;

      if (enq_gnt_s) begin
         bank_nxt_s[enq_ptr_r] = BANK_ENQ;
         enq_vld_nxt_s         = 1'b1;
         enq_idx_nxt_s         = enq_ptr_r;
      end else if (enq_rel_s) begin
         bank_nxt_s[enq_ptr_r] = BANK_SRT_PEND;
         enq_vld_nxt_s         = 1'b0;
         enq_ptr_nxt_s         = ptr_inc(enq_ptr_r);
      end else begin
         enq_vld_nxt_s         = enq_gnt_vld_r;
      end

      if (srt_gnt_s) begin
         bank_nxt_s[srt_ptr_r] = BANK_SRT;
         srt_vld_nxt_s         = 1'b1;
         srt_idx_nxt_s         = srt_ptr_r;
      end else if (srt_rel_s) begin
         bank_nxt_s[srt_ptr_r] = BANK_DEQ_PEND;
         srt_vld_nxt_s         = 1'b0;
         srt_ptr_nxt_s         = ptr_inc(srt_ptr_r);
      end else begin
         srt_vld_nxt_s         = srt_gnt_vld_r;
      end

      if (deq_gnt_s) begin
         bank_nxt_s[deq_ptr_r] = BANK_DEQ;
         deq_vld_nxt_s         = 1'b1;
         deq_idx_nxt_s         = deq_ptr_r;
      end else if (deq_rel_s) begin
         bank_nxt_s[deq_ptr_r] = BANK_FREE;
         deq_vld_nxt_s         = 1'b0;
         deq_ptr_nxt_s         = ptr_inc(deq_ptr_r);
      end else begin
         deq_vld_nxt_s         = deq_gnt_vld_r;
      end

      // Only an enq grant consumes a free bank and only a deq release returns one.
      // When both happen in the same cycle they cancel out.
      if (enq_gnt_s && !deq_rel_s) begin
         free_nxt_s = free_cnt_r - (IDX_W + 1)'(1);
      end else if (!enq_gnt_s && deq_rel_s) begin
         free_nxt_s = free_cnt_r + (IDX_W + 1)'(1);
      end else begin
         free_nxt_s = free_cnt_r;
      end
   end

   // State register.  Reset drops every ownership and returns all banks to FREE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < BANKS_N; i++) begin
            bank_r[i] <= BANK_FREE;
         end
         enq_ptr_r     <= '0;
         srt_ptr_r     <= '0;
         deq_ptr_r     <= '0;
         enq_gnt_vld_r <= 1'b0;
         srt_gnt_vld_r <= 1'b0;
         deq_gnt_vld_r <= 1'b0;
         enq_gnt_idx_r <= '0;
         srt_gnt_idx_r <= '0;
         deq_gnt_idx_r <= '0;
         free_cnt_r    <= FREE_ALL;
      end else begin
         bank_r        <= bank_nxt_s;
         enq_ptr_r     <= enq_ptr_nxt_s;
         srt_ptr_r     <= srt_ptr_nxt_s;
         deq_ptr_r     <= deq_ptr_nxt_s;
         enq_gnt_vld_r <= enq_vld_nxt_s;
         srt_gnt_vld_r <= srt_vld_nxt_s;
         deq_gnt_vld_r <= deq_vld_nxt_s;
         enq_gnt_idx_r <= enq_idx_nxt_s;
         srt_gnt_idx_r <= srt_idx_nxt_s;
         deq_gnt_idx_r <= deq_idx_nxt_s;
         free_cnt_r    <= free_nxt_s;
      end
   end

`ifdef QS_BANK_SCHED_ERR_EN
   logic stray_s;

   // A done pulse from a stage that holds no grant is a protocol violation.
   // The decode above already ignores such a pulse.
   assign stray_s = (enq_done && !enq_gnt_vld_r) ||
                    (srt_done && !srt_gnt_vld_r) ||
                    (deq_done && !deq_gnt_vld_r);

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | stray_s;
      end
   end
`else
   assign err_r = 1'b0;
`endif

endmodule

// File: tb/tb_qs_bank_sched.sv
// tb_qs_bank_sched: directed scenarios, then a randomized run.
// A queue-based reference model (banks as FIFO tokens plus an occupancy count)
// predicts the grants.  A negedge monitor checks every DUT grant against the
// scoreboard, and checks free count, error flag and ownership each cycle.
module tb_qs_bank_sched;
   localparam int N  = 2;
   localparam int IW = $clog2(N);
`ifdef QS_BANK_SCHED_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      int cyc;
      int idx;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req  [3];
   logic          done [3];
   logic [2:0]    gvld;
   logic [IW-1:0] gidx [3];
   logic [IW:0]   free_cnt;
   logic          err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_on = 1'b0;
   bit prev [3];

   // reference model state
   bit   m_own [3];
   int   m_idx [3];
   int   m_occ = 0;
   int   m_enq_next = 0;
   bit   m_err = 1'b0;
   int   pend_srt [$];
   int   pend_deq [$];
   exp_t exp_enq [$];
   exp_t exp_srt [$];
   exp_t exp_deq [$];

   qs_bank_sched #(.BANKS_N(N)) dut (
      .clk(clk), .rst(rst),
      .enq_req(req[0]), .enq_done(done[0]), .enq_gnt_vld_r(gvld[0]), .enq_gnt_idx_r(gidx[0]),
      .srt_req(req[1]), .srt_done(done[1]), .srt_gnt_vld_r(gvld[1]), .srt_gnt_idx_r(gidx[1]),
      .deq_req(req[2]), .deq_done(done[2]), .deq_gnt_vld_r(gvld[2]), .deq_gnt_idx_r(gidx[2]),
      .free_cnt_r(free_cnt), .err_r(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Advance the model by one clock edge, using the inputs that edge sampled.
   task automatic model_step();
      bit g [3];
      bit r [3];
      cyc++;
      if (!rst) begin
         for (int s = 0; s < 3; s++) begin
            m_own[s] = 1'b0;
            m_idx[s] = 0;
         end
         m_occ = 0;
         m_enq_next = 0;
         m_err = 1'b0;
         pend_srt.delete();
         pend_deq.delete();
      end else begin
         g[0] = req[0] && !m_own[0] && (m_occ < N);
         g[1] = req[1] && !m_own[1] && (pend_srt.size() > 0);
         g[2] = req[2] && !m_own[2] && (pend_deq.size() > 0);
         for (int s = 0; s < 3; s++) begin
            r[s] = done[s] && m_own[s];
            if (ERR_EN && done[s] && !m_own[s]) m_err = 1'b1;
         end
         if (g[0]) begin
            m_own[0] = 1'b1; m_idx[0] = m_enq_next; m_occ++;
            exp_enq.push_back('{cyc, m_idx[0]});
         end
         if (g[1]) begin
            m_own[1] = 1'b1; m_idx[1] = pend_srt.pop_front();
            exp_srt.push_back('{cyc, m_idx[1]});
         end
         if (g[2]) begin
            m_own[2] = 1'b1; m_idx[2] = pend_deq.pop_front();
            exp_deq.push_back('{cyc, m_idx[2]});
         end
         if (r[0]) begin
            m_own[0] = 1'b0; pend_srt.push_back(m_idx[0]); m_enq_next = (m_enq_next + 1) % N;
         end
         if (r[1]) begin
            m_own[1] = 1'b0; pend_deq.push_back(m_idx[1]);
         end
         if (r[2]) begin
            m_own[2] = 1'b0; m_occ--;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   // Scoreboard pop for one stage: a DUT grant edge must match the oldest expected grant.
   task automatic scb(input int s, input bit rise);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (s)
         0: if (exp_enq.size() > 0 && (rise || exp_enq[0].cyc <= cyc)) begin e = exp_enq.pop_front(); have = 1'b1; end
         1: if (exp_srt.size() > 0 && (rise || exp_srt[0].cyc <= cyc)) begin e = exp_srt.pop_front(); have = 1'b1; end
         default: if (exp_deq.size() > 0 && (rise || exp_deq[0].cyc <= cyc)) begin e = exp_deq.pop_front(); have = 1'b1; end
      endcase
      if (rise) begin
         chk($sformatf("gnt%0d_expected", s), int'(have), 1);
         if (have) begin
            chk($sformatf("gnt%0d_cycle", s), cyc, e.cyc);
            chk($sformatf("gnt%0d_idx", s), int'(gidx[s]), e.idx);
         end
      end else if (have) begin
         chk($sformatf("gnt%0d_missed", s), int'(rise), 1);
      end
   endtask

   // Monitor: sample away from the active edge and compare against the model.
   always @(negedge clk) begin
      if (mon_on) begin
         for (int s = 0; s < 3; s++) begin
            scb(s, gvld[s] && !prev[s]);
            chk($sformatf("vld%0d", s), int'(gvld[s]), int'(m_own[s]));
            if (gvld[s] && m_own[s]) chk($sformatf("idx%0d", s), int'(gidx[s]), m_idx[s]);
            prev[s] = gvld[s];
         end
         chk("free_cnt", int'(free_cnt), N - m_occ);
         chk("err", int'(err), int'(m_err));
      end
   end

   initial begin
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         req[s] = 1'b0; done[s] = 1'b0; prev[s] = 1'b0; m_own[s] = 1'b0; m_idx[s] = 0;
      end
      tick();
      mon_on = 1'b1;
      tick();
      chk("rst_free", int'(free_cnt), N);
      chk("rst_vld", int'(gvld), 0);
      chk("rst_idx", int'(gidx[0]) + int'(gidx[1]) + int'(gidx[2]), 0);
      chk("rst_err", int'(err), 0);

      // first grant right after reset
      rst = 1'b1; req[0] = 1'b1;
      tick();
      chk("first_gnt_vld", int'(gvld[0]), 1);
      chk("first_gnt_idx", int'(gidx[0]), 0);
      chk("first_gnt_free", int'(free_cnt), 1);
      tick();
      chk("gnt_hold", int'(gvld[0]), 1);

      // bank 0 through the whole pipeline, two-cycle handoffs
      req[0] = 1'b0; done[0] = 1'b1; req[1] = 1'b1;
      tick();
      done[0] = 1'b0;
      chk("enq_rel", int'(gvld[0]), 0);
      chk("srt_not_yet", int'(gvld[1]), 0);
      tick();
      chk("srt_gnt", int'(gvld[1]), 1);
      chk("srt_idx", int'(gidx[1]), 0);
      req[1] = 1'b0; done[1] = 1'b1; req[2] = 1'b1;
      tick();
      done[1] = 1'b0;
      chk("deq_not_yet", int'(gvld[2]), 0);
      tick();
      chk("deq_gnt", int'(gvld[2]), 1);
      chk("deq_idx", int'(gidx[2]), 0);
      req[2] = 1'b0; done[2] = 1'b1;
      tick();
      done[2] = 1'b0;
      chk("pipe_free", int'(free_cnt), 2);

      // full stall and pointer wrap
      rst = 1'b0;
      tick();
      rst = 1'b1; req[0] = 1'b1;
      tick();
      done[0] = 1'b1;
      tick();
      done[0] = 1'b0;
      tick();
      chk("fill_idx1", int'(gidx[0]), 1);
      done[0] = 1'b1;
      tick();
      done[0] = 1'b0;
      tick();
      tick();
      chk("stall_vld", int'(gvld[0]), 0);
      chk("stall_free", int'(free_cnt), 0);
      req[1] = 1'b1;
      tick();
      req[1] = 1'b0; done[1] = 1'b1;
      tick();
      done[1] = 1'b0; req[2] = 1'b1;
      tick();
      req[2] = 1'b0; done[2] = 1'b1;
      tick();
      done[2] = 1'b0;
      chk("wrap_not_yet", int'(gvld[0]), 0);
      tick();
      chk("wrap_vld", int'(gvld[0]), 1);
      chk("wrap_idx", int'(gidx[0]), 0);
      req[0] = 1'b0;

      // simultaneous enq grant on bank 1 and deq release of bank 0
      rst = 1'b0;
      tick();
      rst = 1'b1; req[0] = 1'b1;
      tick();
      req[0] = 1'b0; done[0] = 1'b1;
      tick();
      done[0] = 1'b0; req[1] = 1'b1;
      tick();
      req[1] = 1'b0; done[1] = 1'b1;
      tick();
      done[1] = 1'b0; req[2] = 1'b1;
      tick();
      req[2] = 1'b0;
      chk("sim_pre_free", int'(free_cnt), 1);
      req[0] = 1'b1; done[2] = 1'b1;
      tick();
      req[0] = 1'b0; done[2] = 1'b0;
      chk("sim_enq_idx", int'(gidx[0]), 1);
      chk("sim_deq_vld", int'(gvld[2]), 0);
      chk("sim_free", int'(free_cnt), 1);

      // stray srt done
      done[1] = 1'b1;
      tick();
      done[1] = 1'b0;
      chk("stray_err", int'(err), int'(ERR_EN));
      chk("stray_srt_vld", int'(gvld[1]), 0);
      chk("stray_free", int'(free_cnt), 1);

      // reset while stages hold grants
      done[0] = 1'b1;
      tick();
      done[0] = 1'b0; req[0] = 1'b1; req[1] = 1'b1;
      tick();
      chk("busy_enq_idx", int'(gidx[0]), 0);
      chk("busy_srt_idx", int'(gidx[1]), 1);
      rst = 1'b0;
      tick();
      chk("midrst_vld", int'(gvld), 0);
      chk("midrst_free", int'(free_cnt), 2);
      chk("midrst_err", int'(err), 0);
      rst = 1'b1; req[0] = 1'b0; req[1] = 1'b0;

      // randomized run
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 299) != 0);
         for (int s = 0; s < 3; s++) begin
            req[s]  = ($urandom_range(0, 3) != 0);
            done[s] = ($urandom_range(0, 2) == 0);
         end
         tick();
      end
      for (int s = 0; s < 3; s++) begin
         req[s] = 1'b0; done[s] = 1'b0;
      end
      tick();
      @(negedge clk);
      #1;
      chk("left_enq", exp_enq.size(), 0);
      chk("left_srt", exp_srt.size(), 0);
      chk("left_deq", exp_deq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
